// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register plus the load-use hazard controller for the
// 3-bit-register-address RISC-V core.
//
// Parameters:
//   REG_W    register address width
//   LOAD_LAT load-use stall length in cycles (legal range 1..3)
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   id_valid                           ID holds a real instruction
//   id_rs, id_rt, id_rd                decoded addresses from ID
//   id_uses_rs, id_uses_rt             instruction actually reads rs / rt
//   id_reg_write/mem_read/mem_write    decoded control from ID
//   ex_taken                           branch/jump resolved taken in EX
//   mem_busy                           data memory not ready, freeze front end
//   id_ex_valid, id_ex_rs/rt/rd        registered ID/EX contents
//   id_ex_reg_write/mem_read/mem_write registered control
//   pc_write, if_id_write, if_id_flush front-end control
//   hazard_stall                       load-use stall active this cycle
//   stall_cycles                       saturating load-use stall counter
//
// Optional feature: define ID_EX_STALL_CNT_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module id_ex_stage #(
  parameter int unsigned REG_W    = 3,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_taken,
  input  logic             mem_busy,
  output logic             id_ex_valid,
  output logic [REG_W-1:0] id_ex_rs,
  output logic [REG_W-1:0] id_ex_rt,
  output logic [REG_W-1:0] id_ex_rd,
  output logic             id_ex_reg_write,
  output logic             id_ex_mem_read,
  output logic             id_ex_mem_write,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             hazard_stall,
  output logic [15:0]      stall_cycles
);

  typedef enum logic {StRun, StStall} state_e;

  // Cycles still to spend in StStall after the cycle that detected load-use.
  localparam logic [1:0] StallInit = 2'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use;
  logic       ex_load;    // ID/EX register updates this cycle
  logic       ex_bubble;  // ...and the update is a bubble

  assign load_use = id_valid && id_ex_valid && id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == id_ex_rd)) ||
                     (id_uses_rt && (id_rt == id_ex_rd)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; rule priority is freeze > redirect > stall > load-use > run
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_load   = 1'b0;
    ex_bubble = 1'b0;
    if (mem_busy) begin
      // everything holds
    end else if (ex_taken) begin
      ex_load   = 1'b1;
      ex_bubble = 1'b1;
      state_d   = StRun;
      cnt_d     = 2'd0;
    end else if (state_q == StStall) begin
      ex_load   = 1'b1;
      ex_bubble = 1'b1;
      cnt_d     = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = StRun;
    end else if (load_use) begin
      ex_load   = 1'b1;
      ex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = StStall;
        cnt_d   = StallInit;
      end
    end else begin
      ex_load   = 1'b1;
      ex_bubble = !id_valid;
    end
  end

  // Front-end control outputs; all low while reset is held
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    hazard_stall = 1'b0;
    if (!rst_n) begin
      // all low
    end else if (mem_busy) begin
      hazard_stall = (state_q == StStall);
    end else if (ex_taken) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
    end else if (state_q == StStall || load_use) begin
      hazard_stall = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid     <= 1'b0;
      id_ex_rs        <= '0;
      id_ex_rt        <= '0;
      id_ex_rd        <= '0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
    end else if (ex_load) begin
      if (ex_bubble) begin
        id_ex_valid     <= 1'b0;
        id_ex_rs        <= '0;
        id_ex_rt        <= '0;
        id_ex_rd        <= '0;
        id_ex_reg_write <= 1'b0;
        id_ex_mem_read  <= 1'b0;
        id_ex_mem_write <= 1'b0;
      end else begin
        id_ex_valid     <= 1'b1;
        id_ex_rs        <= id_rs;
        id_ex_rt        <= id_rt;
        id_ex_rd        <= id_rd;
        id_ex_reg_write <= id_reg_write;
        id_ex_mem_read  <= id_mem_read;
        id_ex_mem_write <= id_mem_write;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (hazard_stall && !mem_busy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic       ex_taken, mem_busy;

  // index 0: LOAD_LAT=1 instance, index 1: LOAD_LAT=3 instance
  logic [1:0]       o_valid, o_rw, o_mr, o_mw, o_pc, o_ifw, o_fl, o_hs;
  logic [1:0][2:0]  o_rs, o_rt, o_rd;
  logic [1:0][15:0] o_sc;

  always #5 clk = ~clk;

  id_ex_stage #(.REG_W(3), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_taken(ex_taken), .mem_busy(mem_busy),
    .id_ex_valid(o_valid[0]), .id_ex_rs(o_rs[0]), .id_ex_rt(o_rt[0]), .id_ex_rd(o_rd[0]),
    .id_ex_reg_write(o_rw[0]), .id_ex_mem_read(o_mr[0]), .id_ex_mem_write(o_mw[0]),
    .pc_write(o_pc[0]), .if_id_write(o_ifw[0]), .if_id_flush(o_fl[0]),
    .hazard_stall(o_hs[0]), .stall_cycles(o_sc[0])
  );

  id_ex_stage #(.REG_W(3), .LOAD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_taken(ex_taken), .mem_busy(mem_busy),
    .id_ex_valid(o_valid[1]), .id_ex_rs(o_rs[1]), .id_ex_rt(o_rt[1]), .id_ex_rd(o_rd[1]),
    .id_ex_reg_write(o_rw[1]), .id_ex_mem_read(o_mr[1]), .id_ex_mem_write(o_mw[1]),
    .pc_write(o_pc[1]), .if_id_write(o_ifw[1]), .if_id_flush(o_fl[1]),
    .hazard_stall(o_hs[1]), .stall_cycles(o_sc[1])
  );

  // Reference model: ID/EX contents plus the number of stall cycles still owed.
  typedef struct {
    logic       v;
    logic [2:0] rs, rt, rd;
    logic       rw, mr, mw;
    int         owed;
    int         sc;
  } model_t;

  model_t m [2];
  int     lat [2] = '{1, 3};
  int     vectors = 0;
  int     miscompares = 0;
  logic   last_pc [2], last_fl [2], last_hs [2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s lat%0d: got %0h expected %0h", tag, lat[d], obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic urs, input logic urt,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  // One clock: inputs already applied; compare at mid-cycle, then advance model.
  task automatic cycle();
    logic lu, e_pc, e_ifw, e_fl, e_hs;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) m[d] = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0, mw: 0, owed: 0, sc: 0};
      lu = id_valid && m[d].v && m[d].mr && (m[d].rd != 3'd0) &&
           ((id_uses_rs && id_rs == m[d].rd) || (id_uses_rt && id_rt == m[d].rd));
      e_pc = 0; e_ifw = 0; e_fl = 0; e_hs = 0;
      if (!rst_n) begin
      end else if (mem_busy) e_hs = (m[d].owed > 0);
      else if (ex_taken) begin e_pc = 1; e_ifw = 1; e_fl = 1; end
      else if (m[d].owed > 0 || lu) e_hs = 1;
      else begin e_pc = 1; e_ifw = 1; end

      chk("valid", d, 32'(o_valid[d]), 32'(m[d].v));
      chk("rs", d, 32'(o_rs[d]), 32'(m[d].rs));
      chk("rt", d, 32'(o_rt[d]), 32'(m[d].rt));
      chk("rd", d, 32'(o_rd[d]), 32'(m[d].rd));
      chk("reg_write", d, 32'(o_rw[d]), 32'(m[d].rw));
      chk("mem_read", d, 32'(o_mr[d]), 32'(m[d].mr));
      chk("mem_write", d, 32'(o_mw[d]), 32'(m[d].mw));
      chk("pc_write", d, 32'(o_pc[d]), 32'(e_pc));
      chk("if_id_write", d, 32'(o_ifw[d]), 32'(e_ifw));
      chk("if_id_flush", d, 32'(o_fl[d]), 32'(e_fl));
      chk("hazard_stall", d, 32'(o_hs[d]), 32'(e_hs));
      chk("stall_cycles", d, 32'(o_sc[d]), 32'(m[d].sc));
      last_pc[d] = o_pc[d]; last_fl[d] = o_fl[d]; last_hs[d] = o_hs[d];

      if (rst_n && !mem_busy) begin
`ifdef ID_EX_STALL_CNT_EN
        if (e_hs && m[d].sc < 65535) m[d].sc++;
`endif
        if (ex_taken || m[d].owed > 0 || lu) begin
          if (ex_taken) m[d].owed = 0;
          else if (m[d].owed > 0) m[d].owed--;
          else m[d].owed = lat[d] - 1;
          m[d].v = 0; m[d].rs = 0; m[d].rt = 0; m[d].rd = 0;
          m[d].rw = 0; m[d].mr = 0; m[d].mw = 0;
        end else begin
          m[d].v  = id_valid;
          m[d].rs = id_valid ? id_rs : 3'd0;
          m[d].rt = id_valid ? id_rt : 3'd0;
          m[d].rd = id_valid ? id_rd : 3'd0;
          m[d].rw = id_valid & id_reg_write;
          m[d].mr = id_valid & id_mem_read;
          m[d].mw = id_valid & id_mem_write;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  int hs_count;
  int sc_start;

  initial begin
    rst_n = 0; ex_taken = 0; mem_busy = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++)
      m[d] = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0, mw: 0, owed: 0, sc: 0};
    #2;
    cycle(); cycle();
    rst_n = 1;

    // Pass-through
    set_id(1, 3'd2, 3'd3, 3'd4, 1, 1, 1, 0, 0); cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Load-use: load rd=5 then consumer of r5; LAT3 sees busy twice mid-stall
    sc_start = int'(o_sc[1]);
    set_id(1, 3'd1, 3'd0, 3'd5, 1, 0, 1, 1, 0); cycle();
    set_id(1, 3'd5, 3'd2, 3'd6, 1, 1, 1, 0, 0);
    hs_count = 0;
    cycle(); hs_count += int'(last_hs[1]);
    cycle(); hs_count += int'(last_hs[1]);
    mem_busy = 1;
    cycle(); hs_count += int'(last_hs[1]);
    cycle(); hs_count += int'(last_hs[1]);
    mem_busy = 0;
    cycle(); hs_count += int'(last_hs[1]);
    cycle(); hs_count += int'(last_hs[1]);
    chk("lat3_stall_len", 1, 32'(hs_count), 32'd5);
`ifdef ID_EX_STALL_CNT_EN
    chk("lat3_stall_cnt", 1, 32'(int'(o_sc[1]) - sc_start), 32'd3);
`else
    chk("lat3_stall_cnt", 1, 32'(o_sc[1]), 32'd0);
`endif
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Register zero never stalls
    set_id(1, 3'd1, 3'd0, 3'd0, 1, 0, 1, 1, 0); cycle();
    set_id(1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 0, 0); cycle();
    chk("r0_no_stall", 0, 32'(last_pc[0]), 32'd1);
    chk("r0_no_stall", 1, 32'(last_pc[1]), 32'd1);

    // Redirect beats load-use
    set_id(1, 3'd1, 3'd0, 3'd5, 1, 0, 1, 1, 0); cycle();
    set_id(1, 3'd5, 3'd0, 3'd2, 1, 0, 1, 0, 0); ex_taken = 1; cycle();
    chk("taken_flush", 0, 32'(last_fl[0]), 32'd1);
    chk("taken_flush", 1, 32'(last_fl[1]), 32'd1);
    ex_taken = 0; cycle();

    // Redirect aborts an active LAT3 stall
    set_id(1, 3'd1, 3'd0, 3'd6, 1, 0, 1, 1, 0); cycle();
    set_id(1, 3'd6, 3'd0, 3'd2, 1, 0, 1, 0, 0); cycle();
    ex_taken = 1; cycle();
    chk("abort_stall", 1, 32'(last_hs[1]), 32'd0);
    ex_taken = 0; cycle();

    // Reset in the middle of a LAT3 stall (cnt=2)
    set_id(1, 3'd1, 3'd0, 3'd7, 1, 0, 1, 1, 0); cycle();
    set_id(1, 3'd7, 3'd0, 3'd2, 1, 0, 1, 0, 0); cycle();
    rst_n = 0; cycle();
    rst_n = 1; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("post_reset_run", 1, 32'(last_pc[1]), 32'd1);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 3)),
             3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
             1'($urandom));
      ex_taken = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register combined with the load-use hazard controller for the 3-bit-register-address RISC-V core. It captures decoded register addresses and control bits from ID and presents them to EX. These are the `id_ex_rs`, `id_ex_rt` and `id_ex_rd` values the forwarding unit consumes. It inserts bubbles and holds PC and IF/ID on load-use dependencies, branch redirects and memory back-pressure.

## Interface
Parameters:
- REG_W, 3, register address width
- LOAD_LAT, 1, load-use stall length in cycles; legal range 1..3

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt, id_rd  input  REG_W each  decoded source and destination addresses
- id_uses_rs, id_uses_rt  input  1 each  instruction actually reads rs / rt
- id_reg_write, id_mem_read, id_mem_write  input  1 each  decoded control
- ex_taken  input  1  branch or jump resolved taken in EX this cycle
- mem_busy  input  1  data memory not ready; freeze the front end
- id_ex_valid  output  1  EX holds a real instruction
- id_ex_rs, id_ex_rt, id_ex_rd  output  REG_W each  registered addresses
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write  output  1 each  registered control
- pc_write  output  1  PC may update
- if_id_write  output  1  IF/ID may load
- if_id_flush  output  1  IF/ID must be loaded with a bubble
- hazard_stall  output  1  a load-use stall is active this cycle
- stall_cycles  output  16  load-use stall cycle count (see Configuration)

## Operation
- Bubble: `id_ex_valid` = 0 and all `id_ex_*` fields = 0.
- load_use is asserted when all of the following are true:
  - `id_valid`, `id_ex_valid` and `id_ex_mem_read` are all 1.
  - `id_ex_rd` != 0.
  - `id_uses_rs` is set and `id_rs` == `id_ex_rd`, OR `id_uses_rt` is set and `id_rt` == `id_ex_rd`.
- The FSM has two states, RUN and STALL, and a 2-bit down-counter `cnt`.
- Each cycle, the first matching rule below applies:
  - **Freeze** (`mem_busy`=1): all registers, the state and `cnt` hold. `pc_write`=0, `if_id_write`=0, `if_id_flush`=0. `hazard_stall` reflects the held state.
  - **Redirect** (`ex_taken`=1): ID/EX loads a bubble. `pc_write`=1, `if_id_write`=1, `if_id_flush`=1. Next state is RUN and `cnt` is cleared. An active STALL is aborted.
  - **STALL**: ID/EX loads a bubble. `pc_write`=0, `if_id_write`=0, `hazard_stall`=1. `cnt` decrements; when `cnt` is 1, next state is RUN.
  - **RUN with load_use**: ID/EX loads a bubble. `pc_write`=0, `if_id_write`=0, `hazard_stall`=1.
    - If LOAD_LAT = 1, next state is RUN (a single-cycle stall).
    - Otherwise next state is STALL with `cnt` = LOAD_LAT-1.
  - **RUN, otherwise**: ID/EX loads the ID fields, with `id_ex_valid` = `id_valid`. When `id_valid`=0, all fields load as 0. `pc_write`=1, `if_id_write`=1.
- Total load-use stall is exactly LOAD_LAT non-frozen cycles.
- Load-use detection is never evaluated in STALL; the dependent instruction is re-checked in RUN.

## Timing
- ID/EX outputs are registered with a 1-cycle latency from ID inputs.
- `pc_write`, `if_id_write`, `if_id_flush` and `hazard_stall` are combinational from the current state, `cnt`, ID inputs, ID/EX registers, `ex_taken` and `mem_busy`.
- While `rst_n`=0:
  - All ID/EX outputs are 0, the state is RUN, `cnt`=0 and `stall_cycles`=0.
  - `pc_write`=0, `if_id_write`=0, `if_id_flush`=0, `hazard_stall`=0.
- Reset asserted mid-stall abandons the stall immediately. Reset deasserts into RUN.
- With `mem_busy` held N cycles during a stall, the stall ends N cycles late and its length in non-frozen cycles is unchanged.
- When `ex_taken` and load_use are both 1 in the same cycle, the redirect wins and no stall starts.

## Configuration
- `ID_EX_STALL_CNT_EN` defined: `stall_cycles` increments on every cycle with `hazard_stall`=1 and `mem_busy`=0. It saturates at 16'hFFFF and is cleared only by reset.
- `ID_EX_STALL_CNT_EN` undefined: `stall_cycles` is tied to 16'h0000 and no counter logic is built.

## Test plan
- Pass-through: set `id_valid`=1, rs=2, rt=3, rd=4, `reg_write`=1 with no hazard. Next cycle `id_ex_rs`=2, `id_ex_rt`=3, `id_ex_rd`=4, `id_ex_reg_write`=1, `id_ex_valid`=1; `pc_write`=1 throughout.
- Load-use with LOAD_LAT=1: load rd=5 is in ID/EX, ID holds rs=5 with `uses_rs`=1.
  - Exactly 1 cycle with `pc_write`=0, `hazard_stall`=1 and a bubble in ID/EX.
  - The following cycle, ID/EX receives rs=5.
- Load-use with LOAD_LAT=3 and `mem_busy` pulsed high for 2 cycles in mid-stall:
  - `hazard_stall`=1 for 5 cycles.
  - 3 bubbles enter ID/EX.
  - `stall_cycles` = 3 when the macro is defined, 0 when undefined.
- Register zero: load rd=0 in ID/EX and ID rs=0 → no stall, `pc_write`=1.
- Simultaneous `ex_taken` and load_use → `if_id_flush`=1, `pc_write`=1, bubble in ID/EX, next state RUN. Also: `ex_taken` during STALL with LOAD_LAT=3 aborts the stall in that cycle.
- Reset: assert `rst_n`=0 in STALL with `cnt`=2 → all outputs 0 immediately. After release, the block returns to RUN with `pc_write`=1.
